// File: rtl/sdram_arb.sv
// sdram_arb: grants the SDRAM to the refresh, write or read engine and picks the served client channel.
// Build option: define SDRAM_ARB_RR_EN for round-robin channel selection; otherwise fixed priority (lowest index wins).
module sdram_arb #(
    parameter int NUM_CH  = 2,
    parameter int REF_CNT = 750
) (
    input  logic              sclk,
    input  logic              s_rst_n,
    input  logic              init_end,
    input  logic              ref_end,
    input  logic [NUM_CH-1:0] wr_req,
    input  logic              wr_end,
    input  logic [NUM_CH-1:0] rd_req,
    input  logic              rd_end,
    output logic              ref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic [NUM_CH-1:0] grant
);
    typedef enum logic [2:0] {INIT, IDLE, AREF, WRITE, READ} state_t;

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              ref_req_q, ref_req_d;
    logic              wrap;
    logic              ref_en_q, wr_en_q, rd_en_q;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic [NUM_CH-1:0] wr_sel, rd_sel;

    assign ref_en = ref_en_q;
    assign wr_en  = wr_en_q;
    assign rd_en  = rd_en_q;
    assign grant  = grant_q;

`ifdef SDRAM_ARB_RR_EN
    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [IW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

    // First asserted request found searching upward from ptr+1, wrapping at NUM_CH.
    function automatic logic [NUM_CH-1:0] pick(input logic [NUM_CH-1:0] req, input logic [IW-1:0] ptr);
        logic [NUM_CH-1:0] g;
        int j;
        g = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            j = (int'(ptr) + k) % NUM_CH;
            for (int i = 0; i < NUM_CH; i++)
                if (i == j && req[i]) g = NUM_CH'(1) << i;
        end
        return g;
    endfunction

    function automatic logic [IW-1:0] idx(input logic [NUM_CH-1:0] oh);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (oh[i]) r = IW'(i);
        return r;
    endfunction

    assign wr_sel = pick(wr_req, wr_ptr_q);
    assign rd_sel = pick(rd_req, rd_ptr_q);

    // Each pointer remembers the channel granted on the latest entry into its own burst type.
    always_comb begin
        wr_ptr_d = (state_q == IDLE && state_d == WRITE) ? idx(wr_sel) : wr_ptr_q;
        rd_ptr_d = (state_q == IDLE && state_d == READ)  ? idx(rd_sel) : rd_ptr_q;
    end

    // Pointers reset to the last channel so the first search starts at channel 0.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            wr_ptr_q <= IW'(NUM_CH - 1);
            rd_ptr_q <= IW'(NUM_CH - 1);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
`else
    // Lowest asserted index wins.
    function automatic logic [NUM_CH-1:0] pick(input logic [NUM_CH-1:0] req);
        logic [NUM_CH-1:0] g;
        g = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (req[i]) g = NUM_CH'(1) << i;
        return g;
    endfunction

    assign wr_sel = pick(wr_req);
    assign rd_sel = pick(rd_req);
`endif

    // Refresh interval timer: idle during INIT, free-running afterwards; a wrap raises a single pending request.
    always_comb begin
        wrap      = (state_q != INIT) && (cnt_q == 16'(REF_CNT - 1));
        cnt_d     = (state_q == INIT || wrap) ? 16'd0 : cnt_q + 16'd1;
        ref_req_d = wrap | (ref_req_q & (state_d != AREF));
    end

    // Next state and grant: refresh beats write beats read, and a burst runs until its own end pulse.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            INIT:    state_d = init_end ? IDLE : INIT;
            IDLE: begin
                if (ref_req_q) begin
                    state_d = AREF;
                end else if (|wr_req) begin
                    state_d = WRITE;
                    grant_d = wr_sel;
                end else if (|rd_req) begin
                    state_d = READ;
                    grant_d = rd_sel;
                end
            end
            AREF:    state_d = ref_end ? IDLE : AREF;
            WRITE:   state_d = wr_end ? IDLE : WRITE;
            READ:    state_d = rd_end ? IDLE : READ;
            default: state_d = INIT;
        endcase
        if (state_d != WRITE && state_d != READ) grant_d = '0;
    end

    // State, timer and registered outputs; outputs follow the next state so they line up with it.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q   <= INIT;
            cnt_q     <= 16'd0;
            ref_req_q <= 1'b0;
            ref_en_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            grant_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ref_req_q <= ref_req_d;
            ref_en_q  <= (state_d == AREF);
            wr_en_q   <= (state_d == WRITE);
            rd_en_q   <= (state_d == READ);
            grant_q   <= grant_d;
        end
    end
endmodule
